complex_mul_pipe: RTL

Parametrised, fully pipelined complex multiplier for the FFT datapath (butterfly twiddle multiply, windowing).
- Computes p = a·b, or p = a·conj(b) when selected per sample.
- Full-precision products, then programmable right shift, optional round-half-up and signed saturation to the output width.
- Valid/ready streaming with backpressure, sideband tag passthrough and a per-sample overflow flag.

---
 rtl/cmul_pkg.sv | 33 +++
 rtl/cmul_round_sat.sv | 52 +++++
 rtl/complex_mul_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cmul_pkg.sv
// Shared definitions for the pipelined complex multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: pipeline depth constant, combine-width helper and the signed
// saturation bounds used by the round/saturate stage.
package cmul_pkg;

    // Number of register stages from accepted input to out_valid.
    localparam int PIPE_LAT = 3;

    // Default data/twiddle widths and the matching combine/round width.
    localparam int DW_DEF = 16;
    localparam int TW_DEF = 16;
    localparam int PW     = DW_DEF + TW_DEF + 2;

    // Combine/round width for arbitrary widths: product width DW+TW, one
    // bit of growth from the add/sub, one more so the rounding add cannot wrap.
    function automatic int pw_of(input int dw, input int tw);
        return dw + tw + 2;
    endfunction

    // Largest signed value representable in ow bits.
    function automatic logic signed [63:0] sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    // Smallest signed value representable in ow bits.
    function automatic logic signed [63:0] sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/cmul_round_sat.sv
// Round, arithmetic-shift and saturate one signed component to OW bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; sits ahead of the output registers of the top.
//
// Ports:
//   din  - full-precision combined component, PW bits signed
//   dout - rounded/shifted/saturated component, OW bits signed
//   sat  - 1 when dout was clamped to the max or min of OW bits
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int PW    = 34,
    parameter int OW    = 16,
    parameter int SHIFT = 15,
    parameter int ROUND = 1
)(
    input  logic signed [PW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 sat
);

    // Bit position of the half-LSB; guarded so SHIFT=0 never yields a
    // negative shift amount during elaboration.
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] RND = (ROUND != 0 && SHIFT > 0) ? (ONE <<< RS) : '0;

    localparam logic signed [63:0] SMAX = sat_max(OW);
    localparam logic signed [63:0] SMIN = sat_min(OW);

    logic signed [PW-1:0] sum;
    logic signed [PW-1:0] shf;
    logic signed [63:0]   wide;

    always_comb begin
        // din carries one spare top bit, so adding the half-LSB cannot wrap.
        sum  = din + RND;
        shf  = sum >>> SHIFT;
        // Compare at 64 bits so any OW/PW combination uses the same bounds.
        wide = {{(64-PW){shf[PW-1]}}, shf};
        dout = wide[OW-1:0];
        sat  = 1'b0;
        if (wide > SMAX) begin
            dout = SMAX[OW-1:0];
            sat  = 1'b1;
        end else if (wide < SMIN) begin
            dout = SMIN[OW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/complex_mul_pipe.sv
// Fully pipelined complex multiply p = a*b or a*conj(b), round/shift/saturate.
// Latency: 3 cycles from accepted input to out_valid, 1 sample/cycle.
// Backpressure: global stall, in_ready = ~out_valid | out_ready; all stages hold.
//
// Ports:
//   clk, rst                  - clock (rising edge), async active-high reset
//   in_valid/in_ready         - input handshake
//   a_re,a_im / b_re,b_im     - signed data and twiddle operands
//   conj                      - 1 selects a*conj(b) for this sample
//   in_tag / out_tag          - sideband carried alongside the sample
//   out_valid/out_ready       - output handshake
//   p_re, p_im, ovf           - saturated result and per-sample overflow flag
module complex_mul_pipe
    import cmul_pkg::*;
#(
    parameter int DW    = 16,
    parameter int TW    = 16,
    parameter int OW    = 16,
    parameter int SHIFT = 15,
    parameter int ROUND = 1,
    parameter int TAGW  = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [DW-1:0]   a_re,
    input  logic signed [DW-1:0]   a_im,
    input  logic signed [TW-1:0]   b_re,
    input  logic signed [TW-1:0]   b_im,
    input  logic                   conj,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [OW-1:0]   p_re,
    output logic signed [OW-1:0]   p_im,
    output logic [TAGW-1:0]        out_tag,
    output logic                   ovf
);

    localparam int PRW   = DW + TW;       // full product width
    localparam int CW    = PRW + 1;       // combine width
    localparam int CMB_W = pw_of(DW, TW); // round/saturate input width

    // Whole pipe advances together; bubbles move with real samples.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: registered operands ----------------
    logic                 s1_vld;
    logic signed [DW-1:0] s1_are, s1_aim;
    logic signed [TW-1:0] s1_bre, s1_bim;
    logic                 s1_conj;
    logic [TAGW-1:0]      s1_tag;

    // ---------------- S2: registered products ----------------
    logic                  s2_vld;
    logic signed [PRW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic                  s2_conj;
    logic [TAGW-1:0]       s2_tag;

    logic signed [PRW-1:0] mul_rr, mul_ii, mul_ri, mul_ir;

    always_comb begin
        mul_rr = PRW'(s1_are) * PRW'(s1_bre);
        mul_ii = PRW'(s1_aim) * PRW'(s1_bim);
        mul_ri = PRW'(s1_are) * PRW'(s1_bim);
        mul_ir = PRW'(s1_aim) * PRW'(s1_bre);
    end

    // ---------------- combine ahead of S3 ----------------
    // conj is realised by choosing the sign of the b_im products, never by
    // negating b_im, so the most negative twiddle value stays exact.
    logic signed [CW-1:0]    rr_x, ii_x, ri_x, ir_x;
    logic signed [CW-1:0]    cmb_re, cmb_im;
    logic signed [CMB_W-1:0] ext_re, ext_im;

    always_comb begin
        rr_x   = {s2_rr[PRW-1], s2_rr};
        ii_x   = {s2_ii[PRW-1], s2_ii};
        ri_x   = {s2_ri[PRW-1], s2_ri};
        ir_x   = {s2_ir[PRW-1], s2_ir};
        cmb_re = s2_conj ? (rr_x + ii_x) : (rr_x - ii_x);
        cmb_im = s2_conj ? (ir_x - ri_x) : (ri_x + ir_x);
        ext_re = {cmb_re[CW-1], cmb_re};
        ext_im = {cmb_im[CW-1], cmb_im};
    end

    logic signed [OW-1:0] rs_re, rs_im;
    logic                 sat_re, sat_im;

    cmul_round_sat #(
        .PW    (CMB_W),
        .OW    (OW),
        .SHIFT (SHIFT),
        .ROUND (ROUND)
    ) u_rs_re (
        .din  (ext_re),
        .dout (rs_re),
        .sat  (sat_re)
    );

    cmul_round_sat #(
        .PW    (CMB_W),
        .OW    (OW),
        .SHIFT (SHIFT),
        .ROUND (ROUND)
    ) u_rs_im (
        .din  (ext_im),
        .dout (rs_im),
        .sat  (sat_im)
    );

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_are    <= '0;
            s1_aim    <= '0;
            s1_bre    <= '0;
            s1_bim    <= '0;
            s1_conj   <= 1'b0;
            s1_tag    <= '0;
            s2_vld    <= 1'b0;
            s2_rr     <= '0;
            s2_ii     <= '0;
            s2_ri     <= '0;
            s2_ir     <= '0;
            s2_conj   <= 1'b0;
            s2_tag    <= '0;
            out_valid <= 1'b0;
            p_re      <= '0;
            p_im      <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
        end else if (adv) begin
            // in_ready equals adv, so in_valid here is exactly "accepted".
            s1_vld    <= in_valid;
            s1_are    <= a_re;
            s1_aim    <= a_im;
            s1_bre    <= b_re;
            s1_bim    <= b_im;
            s1_conj   <= conj;
            s1_tag    <= in_tag;
            s2_vld    <= s1_vld;
            s2_rr     <= mul_rr;
            s2_ii     <= mul_ii;
            s2_ri     <= mul_ri;
            s2_ir     <= mul_ir;
            s2_conj   <= s1_conj;
            s2_tag    <= s1_tag;
            out_valid <= s2_vld;
            p_re      <= rs_re;
            p_im      <= rs_im;
            out_tag   <= s2_tag;
            ovf       <= sat_re | sat_im;
        end
    end

endmodule
